// File: rtl/pw_pkg.sv
// Shared definitions for the password verifier: FSM encoding, default
// parameter values and a small index-width helper.
package pw_pkg;

  localparam int DIGITS_DEF      = 4;
  localparam int DIGIT_W_DEF     = 4;
  localparam int MAX_FAIL_DEF    = 3;
  localparam int LOCK_CYCLES_DEF = 1000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPARE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  // Width of a counter able to index n items; never less than one bit.
  function automatic int idx_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pw_verifier_if.sv
// Request/response bundle between the verifier and its client.
interface pw_verifier_if
  import pw_pkg::*;
#(
  parameter int PW_W = DIGITS_DEF * DIGIT_W_DEF
) ();

  logic            start;
  logic [PW_W-1:0] data1;
  logic [PW_W-1:0] data2;
  logic            ready;
  logic            finish;
  logic            match;
  logic            locked;
  logic [3:0]      fail_cnt;

  modport master (
    output start, data1, data2,
    input  ready, finish, match, locked, fail_cnt
  );

  modport slave (
    input  start, data1, data2,
    output ready, finish, match, locked, fail_cnt
  );

endinterface

// File: rtl/pw_verifier_lockout_timer.sv
// Loadable down-counter timing the lockout window; o_done flags the final
// counting cycle so the FSM leaves LOCKED on the edge the count reaches zero.
module lockout_timer
  import pw_pkg::*;
#(
  parameter int LOCK_CYCLES = LOCK_CYCLES_DEF,
  localparam int CNT_W      = $clog2(LOCK_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_en,
  output logic             o_done,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= CNT_W'(LOCK_CYCLES);
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_done  = i_en && (r_count == CNT_W'(1));
  assign o_count = r_count;

endmodule

// File: rtl/pw_verifier.sv
// Constant-time password comparator with consecutive-failure lockout.
// One digit is examined per cycle regardless of earlier mismatches.
module pw_verifier
  import pw_pkg::*;
#(
  parameter int DIGITS      = DIGITS_DEF,
  parameter int DIGIT_W     = DIGIT_W_DEF,
  parameter int MAX_FAIL    = MAX_FAIL_DEF,
  parameter int LOCK_CYCLES = LOCK_CYCLES_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  pw_verifier_if.slave  bus
);

  localparam int PW_W  = DIGITS * DIGIT_W;
  localparam int IDX_W = idx_w(DIGITS);
  localparam int CNT_W = $clog2(LOCK_CYCLES + 1);

  state_t           r_state;
  logic [PW_W-1:0]  r_data1;
  logic [PW_W-1:0]  r_data2;
  logic [IDX_W-1:0] r_idx;
  logic             r_mism;
  logic             r_finish;
  logic             r_match;
  logic             r_locked;
  logic [3:0]       r_fail_cnt;

  logic [DIGITS-1:0] w_digit_ne;
  logic              w_cur_ne;
  logic              w_last;
  logic              w_mism_total;
  logic [3:0]        w_fail_inc;
  logic              w_lock_now;
  logic              w_timer_load;
  logic              w_timer_en;
  logic              w_timer_done;
  logic [CNT_W-1:0]  w_timer_count;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    assign w_digit_ne[gi] = r_data1[gi*DIGIT_W +: DIGIT_W] != r_data2[gi*DIGIT_W +: DIGIT_W];
  end

  assign w_cur_ne     = w_digit_ne[r_idx];
  assign w_last       = (r_idx == IDX_W'(DIGITS - 1));
  assign w_mism_total = r_mism | w_cur_ne;
  assign w_fail_inc   = r_fail_cnt + 4'd1;
  assign w_lock_now   = (r_state == ST_COMPARE) && w_last && w_mism_total &&
                        (w_fail_inc == 4'(MAX_FAIL));
  assign w_timer_load = w_lock_now;
  assign w_timer_en   = (r_state == ST_LOCKED);

  lockout_timer #(
    .LOCK_CYCLES (LOCK_CYCLES)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_timer_load),
    .i_en    (w_timer_en),
    .o_done  (w_timer_done),
    .o_count (w_timer_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_data1    <= '0;
      r_data2    <= '0;
      r_idx      <= '0;
      r_mism     <= 1'b0;
      r_finish   <= 1'b0;
      r_match    <= 1'b0;
      r_locked   <= 1'b0;
      r_fail_cnt <= 4'd0;
    end else begin
      r_finish <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_data1 <= bus.data1;
            r_data2 <= bus.data2;
            r_match <= 1'b0;
            r_idx   <= '0;
            r_mism  <= 1'b0;
            r_state <= ST_COMPARE;
          end
        end
        ST_COMPARE: begin
          r_mism <= w_mism_total;
          r_idx  <= r_idx + IDX_W'(1);
          if (w_last) begin
            r_finish <= 1'b1;
            r_match  <= ~w_mism_total;
            if (!w_mism_total) begin
              r_fail_cnt <= 4'd0;
              r_state    <= ST_IDLE;
            end else if (w_lock_now) begin
              r_fail_cnt <= 4'(MAX_FAIL);
              r_locked   <= 1'b1;
              r_state    <= ST_LOCKED;
            end else begin
              r_fail_cnt <= w_fail_inc;
              r_state    <= ST_IDLE;
            end
          end
        end
        ST_LOCKED: begin
          if (w_timer_done) begin
            r_locked   <= 1'b0;
            r_fail_cnt <= 4'd0;
            r_state    <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.ready    = (r_state == ST_IDLE);
  assign bus.finish   = r_finish;
  assign bus.match    = r_match;
  assign bus.locked   = r_locked;
  assign bus.fail_cnt = r_fail_cnt;

endmodule

// File: tb/tb_pw_verifier.sv
// Scoreboard bench for pw_verifier: each accepted start pushes an expected
// result, each finish pulse pops and compares it.
module tb_pw_verifier;
  import pw_pkg::*;

  localparam int DIGITS      = 4;
  localparam int DIGIT_W     = 4;
  localparam int MAX_FAIL    = 3;
  localparam int LOCK_CYCLES = 8;
  localparam int PW_W        = DIGITS * DIGIT_W;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pw_verifier_if #(.PW_W(PW_W)) bus ();

  pw_verifier #(
    .DIGITS      (DIGITS),
    .DIGIT_W     (DIGIT_W),
    .MAX_FAIL    (MAX_FAIL),
    .LOCK_CYCLES (LOCK_CYCLES)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic       match;
    logic [3:0] fc;
    logic       locked;
    int         fin_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   model_fc = 0;
  int   lock_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.finish) begin
      if (sb.size() == 0) begin
        check("spurious_finish", 32'(bus.finish), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("match",    32'(bus.match),    32'(mon_e.match));
        check("fail_cnt", 32'(bus.fail_cnt), 32'(mon_e.fc));
        check("locked",   32'(bus.locked),   32'(mon_e.locked));
        check("latency",  32'(cyc),          32'(mon_e.fin_cyc));
        $display("txn cyc=%0d match=%0b fail_cnt=%0d locked=%0b", cyc, bus.match,
                 bus.fail_cnt, bus.locked);
      end
    end
    if (bus.locked) check("match_while_locked", 32'(bus.match), 32'd0);
  end

  // Reference model: derives result, failure count and lockout from the operands.
  task automatic model_push(input logic [PW_W-1:0] d1, input logic [PW_W-1:0] d2, input int acc);
    exp_t e;
    if (d1 == d2) model_fc = 0;
    else          model_fc = model_fc + 1;
    e.match   = (d1 == d2);
    e.fc      = 4'(model_fc);
    e.locked  = (model_fc == MAX_FAIL);
    e.fin_cyc = acc + DIGITS;
    sb.push_back(e);
    if (e.locked) model_fc = 0;
  endtask

  task automatic wait_ready(input int budget);
    int n = 0;
    while (!bus.ready && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!bus.ready) check("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic cmp(input logic [PW_W-1:0] d1, input logic [PW_W-1:0] d2);
    wait_ready(50);
    bus.data1 = d1;
    bus.data2 = d2;
    bus.start = 1'b1;
    model_push(d1, d2, cyc + 1);
    @(negedge clk);
    bus.start = 1'b0;
    bus.data1 = 16'($urandom);
    bus.data2 = 16'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() > 0) begin
      check("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  initial begin
    logic [PW_W-1:0] rd1;
    logic [PW_W-1:0] rd2;
    int              n;

    bus.start = 1'b0;
    bus.data1 = '0;
    bus.data2 = '0;
    repeat (2) @(negedge clk);
    check("rst_finish",   32'(bus.finish),   32'd0);
    check("rst_match",    32'(bus.match),    32'd0);
    check("rst_locked",   32'(bus.locked),   32'd0);
    check("rst_fail_cnt", 32'(bus.fail_cnt), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'(bus.ready), 32'd1);

    // Mismatch, match, top-digit-only mismatch, then recovery sequence 1,2,0.
    cmp(16'hF1F1, 16'h1F1F);
    cmp(16'hF1F1, 16'hF1F1);
    cmp(16'h01F1, 16'hF1F1);
    cmp(16'h1234, 16'h1235);
    cmp(16'hABCD, 16'hABCD);
    drain();

    // start pulsed on the three edges following acceptance must be ignored.
    wait_ready(50);
    bus.data1 = 16'h3333;
    bus.data2 = 16'h3330;
    bus.start = 1'b1;
    model_push(16'h3333, 16'h3330, cyc + 1);
    @(negedge clk);
    bus.data1 = 16'h7777;
    bus.data2 = 16'h7777;
    check("busy_ready0", 32'(bus.ready), 32'd0);
    @(negedge clk);
    check("busy_ready1", 32'(bus.ready), 32'd0);
    @(negedge clk);
    check("busy_ready2", 32'(bus.ready), 32'd0);
    @(negedge clk);
    bus.start = 1'b0;
    drain();

    // Two more mismatches reach MAX_FAIL and lock.
    cmp(16'h0000, 16'h0001);
    cmp(16'h8000, 16'h0000);
    n = 0;
    while (!bus.locked && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("lock_rise", 32'(bus.locked), 32'd1);
    lock_cyc = cyc;
    for (int i = 0; i < 3; i++) begin
      bus.start = 1'b1;
      bus.data1 = 16'h5555;
      bus.data2 = 16'h5555;
      check("lock_ready0", 32'(bus.ready), 32'd0);
      @(negedge clk);
    end
    bus.start = 1'b0;
    wait_ready(40);
    check("lock_len",      32'(cyc - lock_cyc), 32'(LOCK_CYCLES));
    check("unlock_locked", 32'(bus.locked),     32'd0);
    check("unlock_fc",     32'(bus.fail_cnt),   32'd0);
    drain();

    // start held high: back-to-back launches every DIGITS+1 cycles.
    wait_ready(50);
    bus.data1 = 16'h5A5A;
    bus.data2 = 16'h5A5A;
    bus.start = 1'b1;
    model_push(16'h5A5A, 16'h5A5A, cyc + 1);
    model_push(16'h5A5A, 16'h5A5A, cyc + 1 + DIGITS + 1);
    repeat (DIGITS + 2) @(negedge clk);
    bus.start = 1'b0;
    drain();

    for (int i = 0; i < 8; i++) begin
      rd1 = 16'($urandom);
      rd2 = ($urandom_range(0, 1) == 1) ? rd1 : (rd1 ^ (16'h1 << $urandom_range(0, 15)));
      cmp(rd1, rd2);
    end
    drain();

    // Reset during a comparison aborts it with no finish pulse.
    cmp(16'h7777, 16'h7777);
    cmp(16'h1111, 16'h2222);
    drain();
    wait_ready(50);
    bus.data1 = 16'h4444;
    bus.data2 = 16'h4440;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_finish",   32'(bus.finish),   32'd0);
    check("abort_match",    32'(bus.match),    32'd0);
    check("abort_locked",   32'(bus.locked),   32'd0);
    check("abort_fail_cnt", 32'(bus.fail_cnt), 32'd0);
    model_fc = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_ready", 32'(bus.ready), 32'd1);
    repeat (6) @(negedge clk);
    cmp(16'hF1F1, 16'hF1F1);
    drain();
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pw_verifier.md
PW_VERIFIER -- requirements
Module: pw_verifier

Interface
REQ-001 Parameter DIGITS, default 4, number of password digits compared.
REQ-002 Parameter DIGIT_W, default 4, bits per digit; password width PW_W = DIGITS*DIGIT_W (default 16).
REQ-003 Parameter MAX_FAIL, default 3, consecutive mismatches that trigger lockout (legal range 1..15).
REQ-004 Parameter LOCK_CYCLES, default 1000, lockout duration in clk cycles (legal range >=1).
REQ-005 clk  input  1  single system clock; all state updates on rising edge.
REQ-006 rst_n  input  1  reset; asynchronous, active-low.
REQ-007 start  input  1  request a comparison; sampled only when ready=1.
REQ-008 data1  input  PW_W  entered password; captured on the accepted start edge.
REQ-009 data2  input  PW_W  stored password; captured on the accepted start edge.
REQ-010 ready  output  1  high in IDLE only (not busy, not locked).
REQ-011 finish  output  1  one-cycle pulse marking a completed comparison.
REQ-012 match  output  1  result of the last completed comparison; held until the next accepted start.
REQ-013 locked  output  1  high while lockout is active.
REQ-014 fail_cnt  output  4  current consecutive-mismatch count.

Function
REQ-015 FSM states: IDLE, COMPARE, LOCKED; the transitions shall be exactly those in REQ-016..REQ-022.
REQ-016 IDLE: when start=1 at edge N, data1/data2 are latched, match cleared, digit index set to 0, and the FSM goes to COMPARE.
REQ-017 COMPARE: one digit (index 0 = LSB digit) compared per cycle; the mismatch flag accumulates as an OR; there is no early exit, so a comparison always takes DIGITS cycles (constant time).
REQ-018 At edge N+DIGITS: finish=1 for exactly one cycle and match = NOT(accumulated mismatch); input changes after edge N do not affect the result.
REQ-019 On match: fail_cnt cleared to 0 at the same edge as finish; FSM returns to IDLE.
REQ-020 On mismatch with fail_cnt+1 < MAX_FAIL: fail_cnt increments; FSM returns to IDLE.
REQ-021 On mismatch with fail_cnt+1 = MAX_FAIL: fail_cnt = MAX_FAIL, locked=1 at the same edge as finish, FSM goes to LOCKED, and the lockout timer is loaded with LOCK_CYCLES.
REQ-022 LOCKED: the timer decrements once per cycle; when it reaches 0, locked=0, fail_cnt=0, and FSM goes to IDLE, so ready is high exactly LOCK_CYCLES cycles after locked rises.
REQ-023 start while ready=0 (COMPARE or LOCKED) shall be ignored and not queued.
REQ-024 start held high continuously shall launch a new comparison on the first IDLE cycle after each finish (back-to-back period DIGITS+1 cycles).
REQ-025 fail_cnt shall never exceed MAX_FAIL and never wrap.
REQ-026 match shall not be asserted at any time while locked=1.

Reset
REQ-027 When rst_n=0 (asynchronous): FSM=IDLE, finish=0, match=0, locked=0, fail_cnt=0, timer=0, latched operands=0.
REQ-028 Reset mid-COMPARE or mid-LOCKED shall abort with no finish pulse; after release, ready=1 on the first clock edge.

Structure
REQ-029 A shared package pw_pkg shall hold the FSM state encoding and the default values of DIGITS, DIGIT_W, MAX_FAIL, and LOCK_CYCLES.
REQ-030 The lockout counter shall be a sub-module lockout_timer (load, count-down, done), sized $clog2(LOCK_CYCLES+1).
REQ-031 Target size: 120-400 lines of RTL total.

Verification (DIGITS=4, DIGIT_W=4, MAX_FAIL=3, LOCK_CYCLES=8)
REQ-032 Mismatch: data1=16'hF1F1, data2=16'h1F1F, start at edge 0 -> finish pulse after edge 4, match=0, fail_cnt=1.
REQ-033 Match: data1=data2=16'hF1F1 -> finish after edge 4, match=1, fail_cnt=0; the same latency when only digit 3 differs (16'h01F1 vs 16'hF1F1 gives match=0 at edge 4, proving no early exit).
REQ-034 Lockout: three mismatches -> locked=1 with the third finish, start ignored for 8 cycles, then locked=0, fail_cnt=0, ready=1.
REQ-035 Recovery: mismatch, mismatch, match -> fail_cnt sequence 1, 2, 0, and locked stays 0.
REQ-036 Busy/reset: start pulsed at edges 1-3 during COMPARE -> ignored; rst_n low at edge 2 of a comparison -> no finish, all outputs 0, and ready=1 after release.
